// File: rtl/cpu_bus_responder_pkg.sv
// -----------------------------------------------------------------------------
// cpu_bus_responder_pkg
// Shared definitions for the CPU bus responder and its register bank:
//   - bus width constants matching the CPU's 32-bit address/data bus
//   - register index constants for the fixed part of the register map
//   - default ID register contents
//   - responder FSM state encoding
//   - helper that classifies read-only register indices
// -----------------------------------------------------------------------------
package cpu_bus_responder_pkg;

    localparam int CPU_ADDR_W = 32;
    localparam int CPU_DATA_W = 32;

    // Word index field is addr[5:2]: a 64-byte window of 32-bit registers.
    localparam int IDX_W = 4;

    localparam logic [IDX_W-1:0] REG_ID   = 4'd0;
    localparam logic [IDX_W-1:0] REG_CNT  = 4'd1;
    localparam logic [IDX_W-1:0] REG_CTRL = 4'd2;

    localparam logic [CPU_DATA_W-1:0] ID_VALUE_DEFAULT = 32'h6583_2001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_HOLD = 2'd3
    } bus_state_e;

    function automatic logic is_read_only(input logic [IDX_W-1:0] idx);
        return (idx == REG_ID) || (idx == REG_CNT);
    endfunction

endpackage

// File: rtl/cpu_bus_responder_regbank.sv
// -----------------------------------------------------------------------------
// cpu_bus_regbank
// Local register bank of the CPU bus responder.
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   idx_i    : word index of the register being accessed
//   we_i     : write strobe (ignored for read-only registers)
//   wdata_i  : full-word write data
//   rdata_o  : combinational read data for idx_i
//   ctrl_o   : live contents of the control register (index 2)
// Register 0 returns the ID constant, register 1 is a free-running cycle
// counter, all other registers are read/write storage.
// -----------------------------------------------------------------------------
module cpu_bus_regbank
    import cpu_bus_responder_pkg::*;
#(
    parameter int                DATA_W    = CPU_DATA_W,
    parameter int                REG_COUNT = 16,
    parameter logic [DATA_W-1:0] ID_VALUE  = ID_VALUE_DEFAULT,
    parameter logic [DATA_W-1:0] CNT_INIT  = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic              we_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic [DATA_W-1:0] ctrl_o
);

    logic [DATA_W-1:0] cnt_q;
    logic [DATA_W-1:0] cnt_d;
    logic [DATA_W-1:0] regs_q [REG_COUNT];

    // Counter runs every clock regardless of bus activity and wraps naturally.
    assign cnt_d = cnt_q + DATA_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= CNT_INIT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < REG_COUNT; k++) begin
                regs_q[k] <= '0;
            end
        end else if (we_i && !is_read_only(idx_i)) begin
            regs_q[idx_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = regs_q[idx_i];
        if (idx_i == REG_ID) begin
            rdata_o = ID_VALUE;
        end else if (idx_i == REG_CNT) begin
            rdata_o = cnt_q;
        end
    end

    assign ctrl_o = regs_q[REG_CTRL];

endmodule

// File: rtl/cpu_bus_responder.sv
// -----------------------------------------------------------------------------
// cpu_bus_responder
// Memory-mapped responder on the CPU data bus with programmable wait states
// and a four-phase ready handshake.
//   i_cpu_clk        : clock shared with the CPU
//   i_rst_n          : asynchronous active-low reset
//   i_bus_clk        : request strobe, held high for the whole transaction
//   i_bus_we         : 1 = write, 0 = read
//   i_bus_addr       : byte address (bits [1:0] are don't-care)
//   i_bus_data       : write data
//   o_bus_data       : read data, valid while o_bus_data_ready is high
//   o_bus_data_ready : completion flag
//   o_bus_err        : access missed the window or wrote a read-only register
//   o_ctrl           : live contents of register 2
// -----------------------------------------------------------------------------
module cpu_bus_responder
    import cpu_bus_responder_pkg::*;
#(
    parameter int                ADDR_W      = CPU_ADDR_W,
    parameter int                DATA_W      = CPU_DATA_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h0000_FF00,
    parameter int                REG_COUNT   = 16,
    parameter int                WAIT_STATES = 2,
    parameter logic [DATA_W-1:0] ID_VALUE    = ID_VALUE_DEFAULT,
    parameter logic [DATA_W-1:0] CNT_INIT    = '0
) (
    input  logic              i_cpu_clk,
    input  logic              i_rst_n,
    input  logic              i_bus_clk,
    input  logic              i_bus_we,
    input  logic [ADDR_W-1:0] i_bus_addr,
    input  logic [DATA_W-1:0] i_bus_data,
    output logic [DATA_W-1:0] o_bus_data,
    output logic              o_bus_data_ready,
    output logic              o_bus_err,
    output logic [DATA_W-1:0] o_ctrl
);

    bus_state_e        state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic              armed_q, armed_d;
    logic              we_q, we_d;
    logic              hit_q, hit_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rdy_q, rdy_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              hit_live;
    logic [IDX_W-1:0]  idx_live;
    logic              from_idle;
    logic              txn_we, txn_hit;
    logic [IDX_W-1:0]  txn_idx;
    logic [DATA_W-1:0] txn_wdata;
    logic              commit;
    logic [DATA_W-1:0] rb_rdata;
    logic              unused_addr_bits;

    assign idx_live = i_bus_addr[5:2];
    assign hit_live = (i_bus_addr[ADDR_W-1:6] == BASE_ADDR[ADDR_W-1:6])
                   && (int'(idx_live) < REG_COUNT);

    // Byte-lane bits carry no meaning: accesses are full-word only.
    assign unused_addr_bits = ^i_bus_addr[1:0];

    // With zero wait states the response is committed on the capture edge,
    // so the live bus values stand in for the not-yet-loaded capture regs.
    assign from_idle = (state_q == ST_IDLE);
    assign txn_we    = from_idle ? i_bus_we   : we_q;
    assign txn_hit   = from_idle ? hit_live   : hit_q;
    assign txn_idx   = from_idle ? idx_live   : idx_q;
    assign txn_wdata = from_idle ? i_bus_data : wdata_q;

    cpu_bus_regbank #(
        .DATA_W    (DATA_W),
        .REG_COUNT (REG_COUNT),
        .ID_VALUE  (ID_VALUE),
        .CNT_INIT  (CNT_INIT)
    ) u_regbank (
        .clk_i   (i_cpu_clk),
        .rst_ni  (i_rst_n),
        .idx_i   (txn_idx),
        .we_i    (commit && txn_we && txn_hit),
        .wdata_i (txn_wdata),
        .rdata_o (rb_rdata),
        .ctrl_o  (o_ctrl)
    );

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        armed_d = armed_q;
        we_d    = we_q;
        hit_d   = hit_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdy_d   = rdy_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        commit  = 1'b0;

        // A strobe that is still high after a completed transaction or a
        // reset must be seen low once before it can start a new request.
        if (!i_bus_clk) begin
            armed_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_bus_clk && armed_q && !rdy_q) begin
                    armed_d = 1'b0;
                    we_d    = i_bus_we;
                    hit_d   = hit_live;
                    idx_d   = idx_live;
                    wdata_d = i_bus_data;
                    wcnt_d  = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!i_bus_clk) begin
                    state_d = ST_IDLE;
                end else if (wcnt_q == 4'd1) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!i_bus_clk) begin
                    rdy_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Response outputs are registered on the edge entering RESP so they
        // are already valid during the RESP cycle.
        if (commit) begin
            rdy_d = 1'b1;
            err_d = !txn_hit || (txn_we && is_read_only(txn_idx));
            if (!txn_we) begin
                rdata_d = txn_hit ? rb_rdata : '0;
            end
        end
    end

    always_ff @(posedge i_cpu_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            armed_q <= 1'b0;
            we_q    <= 1'b0;
            hit_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            armed_q <= armed_d;
            we_q    <= we_d;
            hit_q   <= hit_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign o_bus_data       = rdata_q;
    assign o_bus_data_ready = rdy_q;
    assign o_bus_err        = err_q;

endmodule
